sr_ff_bank: RTL and testbench



---
 rtl/sr_pkg.sv | 11 +
 rtl/sr_cell.sv | 82 ++++++++
 rtl/sr_ff_bank.sv | 121 ++++++++++++
 tb/tb_sr_ff_bank.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared types for the sr_ff_bank set/reset flag bank: S=R=1 resolution modes.
package sr_pkg;

   typedef enum logic [1:0] {
      SR_MODE_RST_DOM = 2'd0,
      SR_MODE_SET_DOM = 2'd1,
      SR_MODE_TOGGLE  = 2'd2,
      SR_MODE_HOLD    = 2'd3
   } sr_mode_t;

endpackage : sr_pkg

// File: rtl/sr_cell.sv
// One set/reset channel: registered q/qb, edge pulses and a sticky conflict flag.
module sr_cell
   import sr_pkg::*;
#(
   parameter sr_mode_t MODE    = SR_MODE_RST_DOM,
   parameter logic     RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic s,
   input  logic r,
   input  logic clr_err,
   output logic q,
   output logic qb,
   output logic rise,
   output logic fall,
   output logic conflict_err,
   output logic conflict
);

   logic q_q, q_d, qb_q, rise_q, rise_d, fall_q, fall_d, err_q, err_d;

   assign conflict = en & s & r;

   // Next state, edge detection against the current q, and sticky flag update
   always_comb begin
      q_d = q_q;
      if (en) begin
         case ({s, r})
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            2'b11: begin
               case (MODE)
                  SR_MODE_RST_DOM: q_d = 1'b0;
                  SR_MODE_SET_DOM: q_d = 1'b1;
                  SR_MODE_TOGGLE:  q_d = ~q_q;
                  SR_MODE_HOLD:    q_d = q_q;
                  default:         q_d = q_q;
               endcase
            end
            default: q_d = q_q;
         endcase
      end else begin
         q_d = q_q;
      end
      rise_d = ~q_q & q_d;
      fall_d = q_q & ~q_d;
      // A fresh conflict outranks a simultaneous clear
      if (conflict) begin
         err_d = 1'b1;
      end else if (clr_err) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // Channel state registers; qb is stored, not derived, so it is glitch-free
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q    <= RST_VAL;
         qb_q   <= ~RST_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         q_q    <= q_d;
         qb_q   <= ~q_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         err_q  <= err_d;
      end
   end

   assign q            = q_q;
   assign qb           = qb_q;
   assign rise         = rise_q;
   assign fall         = fall_q;
   assign conflict_err = err_q;

endmodule : sr_cell

// File: rtl/sr_ff_bank.sv
// Bank of N synchronous set/reset flags with conflict tracking.
// Optional macro SR_INPUT_SYNC_EN adds 2-flop synchronisers on en/s/r.
module sr_ff_bank
   import sr_pkg::*;
#(
   parameter int             N       = 4,
   parameter int             MODE    = 0,
   parameter logic [N-1:0]   RST_VAL = {N{1'b0}},
   parameter int             CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     en,
   input  logic [N-1:0]     s,
   input  logic [N-1:0]     r,
   input  logic             clr_err,
   output logic [N-1:0]     q,
   output logic [N-1:0]     qb,
   output logic [N-1:0]     rise,
   output logic [N-1:0]     fall,
   output logic [N-1:0]     conflict_err,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam sr_mode_t         MODE_E  = sr_mode_t'(MODE[1:0]);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   generate
      if (MODE < 0 || MODE > 3) begin : g_bad_mode
         $error("sr_ff_bank: MODE must be 0..3");
      end
      if (N < 1 || N > 32) begin : g_bad_n
         $error("sr_ff_bank: N must be 1..32");
      end
      if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
         $error("sr_ff_bank: CNT_W must be 2..16");
      end
   endgenerate

   logic [N-1:0] en_u, s_u, r_u, conflict_s;

`ifdef SR_INPUT_SYNC_EN
   logic [N-1:0] en_m_q, en_s_q, s_m_q, s_s_q, r_m_q, r_s_q;

   // Two-stage synchronisers for asynchronous request sources
   always_ff @(posedge clk) begin
      if (rst) begin
         en_m_q <= {N{1'b0}};
         en_s_q <= {N{1'b0}};
         s_m_q  <= {N{1'b0}};
         s_s_q  <= {N{1'b0}};
         r_m_q  <= {N{1'b0}};
         r_s_q  <= {N{1'b0}};
      end else begin
         en_m_q <= en;
         en_s_q <= en_m_q;
         s_m_q  <= s;
         s_s_q  <= s_m_q;
         r_m_q  <= r;
         r_s_q  <= r_m_q;
      end
   end

   assign en_u = en_s_q;
   assign s_u  = s_s_q;
   assign r_u  = r_s_q;
`else
   assign en_u = en;
   assign s_u  = s;
   assign r_u  = r;
`endif

   for (genvar i = 0; i < N; i++) begin : g_cell
      sr_cell #(
         .MODE    (MODE_E),
         .RST_VAL (RST_VAL[i])
      ) u_cell (
         .clk          (clk),
         .rst          (rst),
         .en           (en_u[i]),
         .s            (s_u[i]),
         .r            (r_u[i]),
         .clr_err      (clr_err),
         .q            (q[i]),
         .qb           (qb[i]),
         .rise         (rise[i]),
         .fall         (fall[i]),
         .conflict_err (conflict_err[i]),
         .conflict     (conflict_s[i])
      );
   end

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             any_conflict_s;

   // Counts conflict cycles, not conflicting channels; saturates instead of wrapping
   always_comb begin
      any_conflict_s = |conflict_s;
      cnt_d          = cnt_q;
      if (clr_err) begin
         cnt_d = any_conflict_s ? CNT_ONE : {CNT_W{1'b0}};
      end else if (any_conflict_s && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Conflict counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign conflict_cnt = cnt_q;

endmodule : sr_ff_bank

// File: tb/tb_sr_ff_bank.sv
// Directed bench for sr_ff_bank: four instances (MODE 0..3, the MODE 3 one with CNT_W=2).
module tb_sr_ff_bank;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] en = 4'b0000, s = 4'b0000, r = 4'b0000;
   logic       clr_err = 1'b0;

   logic [3:0] q_w [4], qb_w [4], rise_w [4], fall_w [4], err_w [4];
   logic [7:0] cnt_w [3];
   logic [1:0] cnt3_w;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sr_ff_bank #(.N(4), .MODE(0), .RST_VAL(4'b1010), .CNT_W(8)) u0 (
      .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
      .q(q_w[0]), .qb(qb_w[0]), .rise(rise_w[0]), .fall(fall_w[0]),
      .conflict_err(err_w[0]), .conflict_cnt(cnt_w[0]));
   sr_ff_bank #(.N(4), .MODE(1), .RST_VAL(4'b1010), .CNT_W(8)) u1 (
      .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
      .q(q_w[1]), .qb(qb_w[1]), .rise(rise_w[1]), .fall(fall_w[1]),
      .conflict_err(err_w[1]), .conflict_cnt(cnt_w[1]));
   sr_ff_bank #(.N(4), .MODE(2), .RST_VAL(4'b1010), .CNT_W(8)) u2 (
      .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
      .q(q_w[2]), .qb(qb_w[2]), .rise(rise_w[2]), .fall(fall_w[2]),
      .conflict_err(err_w[2]), .conflict_cnt(cnt_w[2]));
   sr_ff_bank #(.N(4), .MODE(3), .RST_VAL(4'b1010), .CNT_W(2)) u3 (
      .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
      .q(q_w[3]), .qb(qb_w[3]), .rise(rise_w[3]), .fall(fall_w[3]),
      .conflict_err(err_w[3]), .conflict_cnt(cnt3_w));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rs, input logic [3:0] e, input logic [3:0] si,
                        input logic [3:0] ri, input logic c);
      rst = rs; en = e; s = si; r = ri; clr_err = c;
   endtask

   task automatic chk(input string tag, input int m, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s u%0d observed=%h expected=%h", tag, m, obs, exp);
      end
   endtask

   // Expected vectors are packed one nibble/byte per instance, u3 most significant
   task automatic chk_q(input string tag, input logic [15:0] e);
      logic [3:0] eq, nq;
      for (int m = 0; m < 4; m++) begin
         eq = e[m*4 +: 4];
         nq = ~eq;
         chk({tag, ".q"}, m, {4'b0000, q_w[m]}, {4'b0000, eq});
         chk({tag, ".qb"}, m, {4'b0000, qb_w[m]}, {4'b0000, nq});
      end
   endtask

   task automatic chk_rf(input string tag, input logic [15:0] er, input logic [15:0] ef);
      for (int m = 0; m < 4; m++) begin
         chk({tag, ".rise"}, m, {4'b0000, rise_w[m]}, {4'b0000, er[m*4 +: 4]});
         chk({tag, ".fall"}, m, {4'b0000, fall_w[m]}, {4'b0000, ef[m*4 +: 4]});
      end
   endtask

   task automatic chk_err(input string tag, input logic [15:0] ee, input logic [31:0] ec);
      logic [7:0] c;
      for (int m = 0; m < 4; m++) begin
         c = (m == 3) ? {6'b000000, cnt3_w} : cnt_w[m];
         chk({tag, ".err"}, m, {4'b0000, err_w[m]}, {4'b0000, ee[m*4 +: 4]});
         chk({tag, ".cnt"}, m, c, ec[m*8 +: 8]);
      end
   endtask

   initial begin
      drive(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tick();
      chk_q("reset", 16'hAAAA);
      chk_rf("reset", 16'h0000, 16'h0000);
      chk_err("reset", 16'h0000, 32'h00000000);

`ifdef SR_INPUT_SYNC_EN
      drive(1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b0);
      tick();
      chk_q("sync1", 16'hAAAA);
      tick();
      chk_q("sync2", 16'hAAAA);
      chk_rf("sync2", 16'h0000, 16'h0000);
      tick();
      chk_q("sync3", 16'hBBBB);
      chk_rf("sync3", 16'h1111, 16'h0000);
`else
      // Set then reset channel 0
      drive(1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b0);
      tick();
      chk_q("set0", 16'hBBBB);
      chk_rf("set0", 16'h1111, 16'h0000);
      drive(1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0);
      tick();
      chk_q("rst0", 16'hAAAA);
      chk_rf("rst0", 16'h0000, 16'h1111);
      drive(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      tick();
      chk_rf("idle", 16'h0000, 16'h0000);

      // Preload q[0]=1, then hold s=r=1 on channel 0 for three cycles
      drive(1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b0);
      tick();
      chk_q("preset", 16'hBBBB);
      drive(1'b0, 4'b1111, 4'b0001, 4'b0001, 1'b0);
      tick();
      chk_q("conf1", 16'hBABA);
      chk_rf("conf1", 16'h0000, 16'h0101);
      tick();
      chk_q("conf2", 16'hBBBA);
      chk_rf("conf2", 16'h0100, 16'h0000);
      tick();
      chk_q("conf3", 16'hBABA);
      chk_rf("conf3", 16'h0000, 16'h0100);
      chk_err("conf3", 16'h1111, 32'h03030303);

      drive(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b1);
      tick();
      chk_q("clr", 16'hBABA);
      chk_err("clr", 16'h0000, 32'h00000000);

      // Multi-channel conflict counts once; disabled channels untouched
      drive(1'b0, 4'b0101, 4'b1111, 4'b1111, 1'b0);
      tick();
      chk_q("multi", 16'hBFFA);
      chk_rf("multi", 16'h0540, 16'h0000);
      chk_err("multi", 16'h5555, 32'h01010101);

      // Saturation on the 2-bit counter
      drive(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0);
      tick();
      chk_err("sat1", 16'h5555, 32'h02020202);
      tick();
      tick();
      tick();
      chk_err("sat4", 16'h5555, 32'h03050505);
      drive(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1);
      tick();
      chk_err("clr_conf", 16'h1111, 32'h01010101);
      drive(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1);
      tick();
      chk_err("clr_only", 16'h0000, 32'h00000000);

      // Reset in the middle of toggling
      drive(1'b0, 4'b1111, 4'b0001, 4'b0001, 1'b0);
      tick();
      drive(1'b1, 4'b1111, 4'b0001, 4'b0001, 1'b0);
      tick();
      chk_q("mid_rst", 16'hAAAA);
      chk_rf("mid_rst", 16'h0000, 16'h0000);
      chk_err("mid_rst", 16'h0000, 32'h00000000);
      drive(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      tick();
      chk_q("post_rst", 16'hAAAA);
      chk_rf("post_rst", 16'h0000, 16'h0000);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_sr_ff_bank
